// File: rtl/axis_frame_arbiter.sv
// Round-robin frame arbiter: shares one header engine among NREQ AXI-Stream sources, holding each grant until TLAST.
// Latency: grant registered one cycle after request; data path is combinational (zero cycles); one idle cycle between frames.
// Backpressure: M_TREADY is routed only to the granted source; all other S_TREADY stay low. Length check under AXIS_FRAME_ARB_LEN_CHECK_EN.
module axis_frame_arbiter #(
    parameter int DW   = 512,
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*DW-1:0]   S_TDATA,
    input  logic [NREQ*DW/8-1:0] S_TKEEP,
    input  logic [NREQ-1:0]      S_TVALID,
    input  logic [NREQ-1:0]      S_TLAST,
    output logic [NREQ-1:0]      S_TREADY,
    input  logic [NREQ*32-1:0]   S_FRAME_SIZE,
    output logic [DW-1:0]        M_TDATA,
    output logic [DW/8-1:0]      M_TKEEP,
    output logic                 M_TVALID,
    output logic                 M_TLAST,
    input  logic                 M_TREADY,
    output logic [31:0]          M_FRAME_SIZE,
    output logic [GW-1:0]        GRANT,
    output logic                 BUSY,
    output logic                 LEN_ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       winner;
    logic                found;
    logic                xfer;
    logic [NREQ-1:0]     vld_rot;
    logic [NREQ-1:0]     vld_sel;
    logic [NREQ-1:0]     last_sel;
    int                  idx;

    // Pick the first requesting source, searching upward from rr_ptr with wrap.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx     = 0;
        vld_rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx     = (int'(rr_ptr) + k) % NREQ;
            vld_rot = S_TVALID >> idx;
            if (!found && vld_rot[0]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // Route the granted source to the engine; nothing is presented outside XFER.
    always_comb begin
        vld_sel  = S_TVALID >> GRANT;
        last_sel = S_TLAST >> GRANT;
        M_TDATA  = DW'(S_TDATA >> (int'(GRANT) * DW));
        M_TKEEP  = (DW/8)'(S_TKEEP >> (int'(GRANT) * (DW/8)));
        M_TVALID = (state == XFER) && vld_sel[0];
        M_TLAST  = (state == XFER) && last_sel[0];
        S_TREADY = '0;
        if (state == XFER) begin
            S_TREADY = NREQ'(M_TREADY) << GRANT;
        end
    end

    assign xfer = M_TVALID && M_TREADY;

    // Grant FSM: latch winner and its frame size on entry, release after the TLAST beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            GRANT        <= '0;
            BUSY         <= 1'b0;
            M_FRAME_SIZE <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        GRANT        <= winner;
                        M_FRAME_SIZE <= 32'(S_FRAME_SIZE >> (int'(winner) * 32));
                        BUSY         <= 1'b1;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    if (xfer && M_TLAST) begin
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                        rr_ptr <= (GRANT == GW'(NREQ - 1)) ? '0 : GRANT + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_FRAME_ARB_LEN_CHECK_EN
    logic [31:0] byte_cnt;
    logic [31:0] beat_bytes;
    logic [31:0] frame_total;

    // Byte total of the frame including the beat currently on the bus.
    always_comb begin
        beat_bytes  = 32'($countones(M_TKEEP));
        frame_total = byte_cnt + beat_bytes;
    end

    // Count delivered bytes per frame; flag (sticky) any frame whose total differs from its size.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            LEN_ERR  <= 1'b0;
        end else if (state == IDLE && found) begin
            byte_cnt <= '0;
        end else if (xfer) begin
            byte_cnt <= frame_total;
            if (M_TLAST && (frame_total != M_FRAME_SIZE)) begin
                LEN_ERR <= 1'b1;
            end
        end
    end
`else
    assign LEN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: directed frames per source, expected beats queued at issue time.
// A negedge monitor pops and compares every accepted output beat (data, keep, last, grant, frame size).
// Direct checks cover reset state, stall behaviour, async reset and the sticky length flag.
module tb_axis_frame_arbiter;
    localparam int DW   = 512;
    localparam int NREQ = 4;
    localparam int GW   = 2;
    localparam int KW   = DW / 8;

    logic                 clk;
    logic                 reset;
    logic [NREQ*DW-1:0]   S_TDATA;
    logic [NREQ*KW-1:0]   S_TKEEP;
    logic [NREQ-1:0]      S_TVALID;
    logic [NREQ-1:0]      S_TLAST;
    logic [NREQ-1:0]      S_TREADY;
    logic [NREQ*32-1:0]   S_FRAME_SIZE;
    logic [DW-1:0]        M_TDATA;
    logic [KW-1:0]        M_TKEEP;
    logic                 M_TVALID;
    logic                 M_TLAST;
    logic                 M_TREADY;
    logic [31:0]          M_FRAME_SIZE;
    logic [GW-1:0]        GRANT;
    logic                 BUSY;
    logic                 LEN_ERR;

    axis_frame_arbiter #(.DW(DW), .NREQ(NREQ), .GW(GW)) dut (
        .clk(clk), .reset(reset),
        .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST),
        .S_TREADY(S_TREADY), .S_FRAME_SIZE(S_FRAME_SIZE),
        .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST),
        .M_TREADY(M_TREADY), .M_FRAME_SIZE(M_FRAME_SIZE),
        .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [31:0]   fsize;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [31:0]   fsize;
        logic [GW-1:0] grant;
    } exp_t;

    beat_t srcq [NREQ][$];
    exp_t  expq [$];
    int    xfer_cyc [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    serial = 0;
    logic  exp_len_err;

    localparam logic [KW-1:0] KEEP_FULL = '1;
    localparam logic [KW-1:0] KEEP_32   = {{(KW-32){1'b0}}, {32{1'b1}}};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Queue one source beat and the beat the engine should see for it.
    task automatic push_beat(input int req, input logic [KW-1:0] keep, input logic last,
                             input logic [31:0] src_fsize, input logic [31:0] exp_fsize,
                             output logic [DW-1:0] data);
        beat_t b;
        exp_t  e;
        serial++;
        data    = {(DW/32){8'(req), 24'(serial)}};
        b.data  = data;
        b.keep  = keep;
        b.last  = last;
        b.fsize = src_fsize;
        srcq[req].push_back(b);
        e.data  = data;
        e.keep  = keep;
        e.last  = last;
        e.fsize = exp_fsize;
        e.grant = GW'(req);
        expq.push_back(e);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!BUSY) timeout(name);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((expq.size() > 0 || BUSY) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout(name);
        @(posedge clk);
        #1;
    endtask

    // Source drivers: present queue heads, retire a beat once it was accepted.
    initial begin
        logic [NREQ-1:0] took;
        beat_t b;
        S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TKEEP = '0; S_FRAME_SIZE = '0;
        forever begin
            @(negedge clk);
            took = S_TVALID & S_TREADY;
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (took[i] && !reset && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    S_TVALID[i]              = 1'b1;
                    S_TLAST[i]               = b.last;
                    S_TDATA[i*DW +: DW]      = b.data;
                    S_TKEEP[i*KW +: KW]      = b.keep;
                    S_FRAME_SIZE[i*32 +: 32] = b.fsize;
                end else begin
                    S_TVALID[i] = 1'b0;
                    S_TLAST[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted output beat must match the next expected beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && M_TVALID && M_TREADY) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat_valid", DW'(M_TVALID), DW'(0));
                end else begin
                    e = expq.pop_front();
                    check("beat_data", M_TDATA, e.data);
                    check("beat_keep", DW'(M_TKEEP), DW'(e.keep));
                    check("beat_last", DW'(M_TLAST), DW'(e.last));
                    check("beat_grant", DW'(GRANT), DW'(e.grant));
                    check("beat_frame_size", DW'(M_FRAME_SIZE), DW'(e.fsize));
                    xfer_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d, d2;
`ifdef AXIS_FRAME_ARB_LEN_CHECK_EN
        exp_len_err = 1'b1;
`else
        exp_len_err = 1'b0;
`endif
        reset = 1'b1;
        M_TREADY = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", DW'(BUSY), DW'(0));
        check("reset_grant", DW'(GRANT), DW'(0));
        check("reset_m_tvalid", DW'(M_TVALID), DW'(0));
        check("reset_s_tready", DW'(S_TREADY), DW'(0));
        check("reset_frame_size", DW'(M_FRAME_SIZE), DW'(0));
        check("reset_len_err", DW'(LEN_ERR), DW'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Single source, 128-byte frame in two full beats.
        @(posedge clk);
        #1;
        push_beat(0, KEEP_FULL, 1'b0, 128, 128, d);
        push_beat(0, KEEP_FULL, 1'b1, 128, 128, d);
        @(negedge clk);
        check("t1_busy_before_grant", DW'(BUSY), DW'(0));
        check("t1_tvalid_before_grant", DW'(M_TVALID), DW'(0));
        @(negedge clk);
        check("t1_busy_after_grant", DW'(BUSY), DW'(1));
        check("t1_frame_size", DW'(M_FRAME_SIZE), DW'(128));
        check("t1_tvalid_after_grant", DW'(M_TVALID), DW'(1));
        @(negedge clk);
        @(negedge clk);
        check("t1_busy_after_last", DW'(BUSY), DW'(0));
        check("t1_tvalid_after_last", DW'(M_TVALID), DW'(0));
        drain("t1_drain");

        // rr_ptr is now 1: with sources 0 and 1 both waiting, 1 goes first.
        push_beat(1, KEEP_FULL, 1'b1, 64, 64, d);
        push_beat(0, KEEP_FULL, 1'b1, 64, 64, d);
        drain("t2_drain");

        // Source 2, three beats, engine stalls on beat 2.
        push_beat(2, KEEP_FULL, 1'b0, 192, 192, d);
        push_beat(2, KEEP_FULL, 1'b0, 192, 192, d2);
        push_beat(2, KEEP_FULL, 1'b1, 192, 192, d);
        wait_busy("t3_wait_grant");
        check("t3_s_tready_go", DW'(S_TREADY), DW'(4'b0100));
        @(posedge clk);
        #1 M_TREADY = 1'b0;
        @(negedge clk);
        check("t3_s_tready_stall1", DW'(S_TREADY), DW'(0));
        check("t3_data_stall1", M_TDATA, d2);
        check("t3_tvalid_stall1", DW'(M_TVALID), DW'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_s_tready_stall2", DW'(S_TREADY), DW'(0));
        check("t3_data_stall2", M_TDATA, d2);
        @(posedge clk);
        #1 M_TREADY = 1'b1;
        @(negedge clk);
        check("t3_s_tready_resume", DW'(S_TREADY), DW'(4'b0100));
        check("t3_data_resume", M_TDATA, d2);
        drain("t3_drain");

        // Source 1 changes its frame size mid-frame; the latched size must hold.
        push_beat(1, KEEP_32, 1'b0, 64, 64, d);
        push_beat(1, KEEP_32, 1'b1, 200, 64, d);
        drain("t4_drain");

        // Reset during beat 2 of a 4-beat frame from source 3.
        push_beat(3, KEEP_FULL, 1'b0, 256, 256, d);
        push_beat(3, KEEP_FULL, 1'b0, 256, 256, d);
        push_beat(3, KEEP_FULL, 1'b0, 256, 256, d);
        push_beat(3, KEEP_FULL, 1'b1, 256, 256, d);
        wait_busy("t5_wait_grant");
        @(posedge clk);
        #4 reset = 1'b1;
        #1;
        check("t5_async_tvalid", DW'(M_TVALID), DW'(0));
        check("t5_async_busy", DW'(BUSY), DW'(0));
        check("t5_async_grant", DW'(GRANT), DW'(0));
        check("t5_async_s_tready", DW'(S_TREADY), DW'(0));
        check("t5_async_frame_size", DW'(M_FRAME_SIZE), DW'(0));
        for (int i = 0; i < NREQ; i++) srcq[i].delete();
        expq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // All four sources requesting one-beat frames from rr_ptr=0.
        xfer_cyc.delete();
        push_beat(0, KEEP_FULL, 1'b1, 64, 64, d);
        push_beat(1, KEEP_FULL, 1'b1, 64, 64, d);
        push_beat(2, KEEP_FULL, 1'b1, 64, 64, d);
        push_beat(3, KEEP_FULL, 1'b1, 64, 64, d);
        push_beat(0, KEEP_FULL, 1'b1, 64, 64, d);
        drain("t6_drain");
        check("t6_frame_count", DW'(xfer_cyc.size()), DW'(5));
        if (xfer_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++)
                check("t6_frame_spacing", DW'(xfer_cyc[i] - xfer_cyc[i-1]), DW'(2));
        end
        check("t6_len_err_clean", DW'(LEN_ERR), DW'(0));

        // Declared 100 bytes, delivered 64 + 32.
        push_beat(1, KEEP_FULL, 1'b0, 100, 100, d);
        push_beat(1, KEEP_32, 1'b1, 100, 100, d);
        drain("t7_drain");
        check("t7_len_err_set", DW'(LEN_ERR), DW'(exp_len_err));
        push_beat(2, KEEP_FULL, 1'b1, 64, 64, d);
        drain("t7_drain_ok");
        check("t7_len_err_sticky", DW'(LEN_ERR), DW'(exp_len_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
